// File: rtl/dadda_pkg.sv
// Shared types and constants for the sequential 16x16 multiplier that
// time-shares one external 8x8 Dadda multiplier over four partial products.
package dadda_pkg;

    localparam int BYTE_W = 8;
    localparam int OP_W   = 16;
    localparam int P_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step index: bit 1 selects the multiplicand byte, bit 0 the multiplier byte.
    typedef logic [1:0] step_t;

    // Place an 8x8 partial product at its weight inside the 32-bit product:
    // step 0 -> <<0, steps 1 and 2 -> <<8, step 3 -> <<16.
    function automatic logic [P_W-1:0] place_pp(input logic [2*BYTE_W-1:0] pp,
                                                input step_t step);
        logic [P_W-1:0] r;
        case (step)
            2'd0:    r = {{(2*BYTE_W){1'b0}}, pp};
            2'd3:    r = {pp, {(2*BYTE_W){1'b0}}};
            default: r = {{BYTE_W{1'b0}}, pp, {BYTE_W{1'b0}}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier controller. Each MUL cycle drives one
// byte pair to the shared external 8x8 multiplier and accumulates the
// returned product at its weight. Valid/ready on both sides.
// Optional build macro MUL_SKIP_ZERO_EN: skip byte-pair steps whose
// partial product is known to be zero (either byte is zero).
module mult16_seq_ctrl
    import dadda_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_a,
    input  logic [OP_W-1:0]     in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      out_p,
    output logic                busy,
    output logic [BYTE_W-1:0]   mul_a,
    output logic [BYTE_W-1:0]   mul_b,
    input  logic [2*BYTE_W-1:0] mul_p
);

    state_t             state_q, state_d;
    step_t              step_q, step_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [OP_W-1:0]    a_q, b_q;
    logic [BYTE_W-1:0]  a_byte, b_byte;
    logic               accept;

    assign accept = in_valid && (state_q == IDLE);

    // Byte pair for the current step.
    assign a_byte = step_q[1] ? a_q[OP_W-1:BYTE_W] : a_q[BYTE_W-1:0];
    assign b_byte = step_q[0] ? b_q[OP_W-1:BYTE_W] : b_q[BYTE_W-1:0];

`ifdef MUL_SKIP_ZERO_EN
    logic [3:0] mask_in, mask_q;
    logic [2:0] first_step, later_step;

    // Lowest needed step at or above 'from'; bit 2 set means none remain.
    function automatic logic [2:0] next_step(input logic [3:0] mask,
                                             input logic [2:0] from);
        logic [2:0] r;
        r = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) r = {1'b0, i[1:0]};
        end
        return r;
    endfunction

    // A step contributes only when both of its bytes are non-zero.
    assign mask_in[0] = (|in_a[BYTE_W-1:0])    && (|in_b[BYTE_W-1:0]);
    assign mask_in[1] = (|in_a[BYTE_W-1:0])    && (|in_b[OP_W-1:BYTE_W]);
    assign mask_in[2] = (|in_a[OP_W-1:BYTE_W]) && (|in_b[BYTE_W-1:0]);
    assign mask_in[3] = (|in_a[OP_W-1:BYTE_W]) && (|in_b[OP_W-1:BYTE_W]);

    assign first_step = next_step(mask_in, 3'd0);
    assign later_step = next_step(mask_q, {1'b0, step_q} + 3'd1);
`endif

    // Next-state, accumulator update and multiplier operand drive.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = MUL;
                    acc_d   = '0;
`ifdef MUL_SKIP_ZERO_EN
                    // With an empty mask, step 0 runs as a no-add pass so
                    // the result still appears one edge after accept.
                    step_d  = first_step[2] ? 2'd0 : first_step[1:0];
`else
                    step_d  = 2'd0;
`endif
                end
            end
            MUL: begin
                mul_a = a_byte;
                mul_b = b_byte;
`ifdef MUL_SKIP_ZERO_EN
                if (mask_q[step_q]) acc_d = acc_q + place_pp(mul_p, step_q);
                if (later_step[2]) state_d = DONE;
                else               step_d  = later_step[1:0];
`else
                acc_d = acc_q + place_pp(mul_p, step_q);
                if (step_q == 2'd3) state_d = DONE;
                else                step_d  = step_q + 2'd1;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator registers; reset discards any partial product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
`ifdef MUL_SKIP_ZERO_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
`ifdef MUL_SKIP_ZERO_EN
            if (accept) mask_q <= mask_in;
`endif
        end
    end

    // Operand capture on accept; operands are data and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_p     = acc_q;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench for mult16_seq_ctrl: directed cases with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_mult16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_a, in_b, mul_p;
    logic [31:0] out_p;
    logic [7:0]  mul_a, mul_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

`ifdef MUL_SKIP_ZERO_EN
    localparam int SKIP_LAT = 1;
`else
    localparam int SKIP_LAT = 4;
`endif

    always #5 clk = ~clk;

    // Parent-level 8x8 multiplier model.
    assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

    mult16_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT at t=%0t", name, $time);
    endtask

    // Expected edges from accept edge to out_valid.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        if (a[7:0]  != 0 && b[7:0]  != 0) n++;
        if (a[7:0]  != 0 && b[15:8] != 0) n++;
        if (a[15:8] != 0 && b[7:0]  != 0) n++;
        if (a[15:8] != 0 && b[15:8] != 0) n++;
`ifdef MUL_SKIP_ZERO_EN
        return (n == 0) ? 1 : n;
`else
        return (n > 4) ? n : 4;
`endif
    endfunction

    // Reference model: operands accepted but not yet delivered.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          qc[$];
    logic        prev_ov = 1'b0, prev_or = 1'b0;
    logic [31:0] prev_p  = '0;

    always @(negedge clk) begin
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            prev_ov <= 1'b0;
            prev_or <= 1'b0;
        end else begin
            chk("in_ready_model", {31'd0, in_ready}, {31'd0, qa.size() == 0});
            chk("busy_model",     {31'd0, busy},     {31'd0, qa.size() != 0});
            if (qa.size() == 0) begin
                chk("mul_a_idle", {24'd0, mul_a}, 32'd0);
                chk("mul_b_idle", {24'd0, mul_b}, 32'd0);
            end
            if (prev_ov && !prev_or) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_p", out_p, prev_p);
            end
            if (out_valid) begin
                if (qa.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!prev_ov) chk("latency", cyc - qc[0] - 1, exp_lat(qa[0], qb[0]));
                    if (out_ready) begin
                        chk("product", out_p, {16'd0, qa[0]} * {16'd0, qb[0]});
                        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                qa.push_back(in_a); qb.push_back(in_b); qc.push_back(cyc);
            end
            prev_ov <= out_valid;
            prev_or <= out_ready;
            prev_p  <= out_p;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [15:0] a, input logic [15:0] b, output bit ok);
        tick();
        in_valid = 1'b1; in_a = a; in_b = b; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        in_valid = 1'b0;
        if (!ok) fail_bound("accept");
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
            tick();
            lat++;
        end
        if (!ok) fail_bound("out_valid");
    endtask

    // One operation with literal expectations; 'hold' = cycles out_ready stays low.
    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] exp_p, input int exp_l, input int hold);
        bit ok;
        int lat;
        logic [31:0] first_p;
        out_ready = (hold == 0);
        accept_op(a, b, ok);
        wait_out(lat, ok);
        if (ok) begin
            chk({name, "_lat"}, lat, exp_l);
            chk({name, "_p"}, out_p, exp_p);
            first_p = out_p;
            for (int i = 1; i <= hold; i++) begin
                tick();
                if (i == hold) out_ready = 1'b1;
                @(negedge clk);
                chk({name, "_stall_p"}, out_p, exp_p);
                chk({name, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                chk({name, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            tick();
            out_ready = 1'b0;
            @(negedge clk);
            chk({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
            chk({name, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        bit ok, done;
        int lat, hs, ac;
        logic [15:0] a, b;

        rst = 1'b1; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_mul_a",     {24'd0, mul_a},     32'd0);
        chk("rst_mul_b",     {24'd0, mul_b},     32'd0);
        chk("rst_out_p",     out_p,              32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;

        directed("basic", 16'h1234, 16'h5678, 32'h06260060, 4, 0);
        directed("max_stall", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4, 3);

        // Back-to-back with in_valid held high.
        tick();
        out_ready = 1'b1; in_valid = 1'b1; in_a = 16'h0102; in_b = 16'h0304;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        if (!ok) fail_bound("b2b_accept1");
        in_a = 16'h00FF; in_b = 16'h0101;
        hs = -1; ac = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (out_valid && hs < 0) begin
                hs = n;
                chk("b2b_first_p", out_p, 32'h00030A08);
            end
            if (in_ready) begin ac = n; break; end
            tick();
        end
        if (ac < 0 || hs < 0) fail_bound("b2b_accept2");
        else chk("b2b_accept_slot", ac, hs + 1);
        tick();
        in_valid = 1'b0;
        wait_out(lat, ok);
        if (ok) chk("b2b_second_p", out_p, 32'h0000FFFF);
        tick();
        out_ready = 1'b0;

        // Reset during step 2 of an operation.
        accept_op(16'hABCD, 16'h1234, ok);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out_p",     out_p,              32'd0);
        done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (out_valid) done = 1'b1;
        end
        chk("midrst_no_result", {31'd0, done}, 32'd0);
        directed("after_rst", 16'd3, 16'd5, 32'h0000000F, exp_lat(16'd3, 16'd5), 0);

        directed("skip_one", 16'h0012, 16'h3400, 32'h0003A800, SKIP_LAT, 0);
        directed("skip_all", 16'h0000, 16'hBEEF, 32'h00000000, SKIP_LAT, 0);

        // Randomized traffic, stalls and ignored in_valid while busy.
        for (int k = 0; k < 150; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            case ($urandom_range(0, 5))
                0: a[7:0]  = 8'd0;
                1: a[15:8] = 8'd0;
                2: b[7:0]  = 8'd0;
                3: b[15:8] = 8'd0;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) tick();
            accept_op(a, b, ok);
            done = 1'b0;
            for (int i = 0; i < 80 && !done; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_a = 16'($urandom); in_b = 16'($urandom);
                @(negedge clk);
                if (out_valid && out_ready) begin
                    done = 1'b1;
                    in_valid = 1'b0;
                end
                tick();
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            if (!done) fail_bound("rand_handshake");
        end

        tick();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
